// File: rtl/divider_iterative.sv
// Sequential radix-2 restoring divider: one quotient bit per clock, start/done handshake.
// Zero divisor short-circuits to DONE with quotient all-ones and the raw dividend as remainder.
// Optional two's-complement support is compiled in with `define DIVIDER_SIGNED_EN; without it
// sign_op_i is ignored and every division is unsigned.
module divider_iterative #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sign_op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  rem_q, rem_d;       // partial remainder R
  logic [WIDTH-1:0]  quo_q, quo_d;       // working quotient Q, starts as |dividend|
  logic [WIDTH-1:0]  dvsr_q, dvsr_d;     // |divisor|
  logic [WIDTH-1:0]  quotient_q, quotient_d;
  logic [WIDTH-1:0]  remainder_q, remainder_d;
  logic              div_zero_q, div_zero_d;

  logic              accept;
  logic [WIDTH-1:0]  dvd_mag;
  logic [WIDTH-1:0]  dvs_mag;
  logic [WIDTH:0]    shifted;
  logic [WIDTH:0]    trial;
  logic [WIDTH-1:0]  iter_rem;
  logic [WIDTH-1:0]  iter_quo;
  logic [WIDTH-1:0]  res_quo;
  logic [WIDTH-1:0]  res_rem;

`ifdef DIVIDER_SIGNED_EN
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dvd_neg;
  logic              dvs_neg;
`else
  logic              unused_sign_op;
  assign unused_sign_op = sign_op_i;
`endif

  // Accept only when not iterating; DONE accepts too so ops can run back to back.
  assign accept = start_i & (state_q != StCalc);

`ifdef DIVIDER_SIGNED_EN
  // Operand magnitudes and result sign flags, taken at accept.
  always_comb begin
    dvd_neg = sign_op_i & dividend_i[WIDTH-1];
    dvs_neg = sign_op_i & divisor_i[WIDTH-1];
    dvd_mag = dvd_neg ? -dividend_i : dividend_i;
    dvs_mag = dvs_neg ? -divisor_i : divisor_i;
  end
`else
  assign dvd_mag = dividend_i;
  assign dvs_mag = divisor_i;
`endif

  // One restoring step: shift {R,Q} left, subtract |divisor|, keep or restore.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvsr_q};
    // trial[WIDTH] set means the subtraction borrowed: restore.
    if (!trial[WIDTH]) begin
      iter_rem = trial[WIDTH-1:0];
      iter_quo = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      iter_rem = shifted[WIDTH-1:0];
      iter_quo = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

`ifdef DIVIDER_SIGNED_EN
  // Sign fix-up on the final step; -32768/-1 wraps naturally to 16'h8000.
  always_comb begin
    res_quo = neg_quo_q ? -iter_quo : iter_quo;
    res_rem = neg_rem_q ? -iter_rem : iter_rem;
  end
`else
  assign res_quo = iter_quo;
  assign res_rem = iter_rem;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
`ifdef DIVIDER_SIGNED_EN
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          if (divisor_i == '0) begin
            state_d     = StDone;
            quotient_d  = '1;
            remainder_d = dividend_i;
            div_zero_d  = 1'b1;
          end else begin
            state_d = StCalc;
            count_d = '0;
            rem_d   = '0;
            quo_d   = dvd_mag;
            dvsr_d  = dvs_mag;
`ifdef DIVIDER_SIGNED_EN
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
`endif
          end
        end
      end
      StCalc: begin
        rem_d   = iter_rem;
        quo_d   = iter_quo;
        count_d = count_q + CntW'(1);
        if (count_q == CntW'(WIDTH - 1)) begin
          state_d     = StDone;
          quotient_d  = res_quo;
          remainder_d = res_rem;
          div_zero_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset taking priority over any operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
`ifdef DIVIDER_SIGNED_EN
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  assign ready_o     = (state_q != StCalc);
  assign busy_o      = (state_q == StCalc);
  assign done_o      = (state_q == StDone);
  assign div_zero_o  = div_zero_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;

endmodule

// File: tb/tb_divider_iterative.sv
// Directed bench for divider_iterative: latency, handshake, zero divisor, reset abort,
// signed/unsigned behaviour and a stream of back-to-back unsigned divisions.
module tb_divider_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sign_op;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        ready;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [15:0] quotient;
  logic [15:0] remainder;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divider_iterative #(.WIDTH(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .sign_op_i   (sign_op),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .ready_o     (ready),
    .busy_o      (busy),
    .done_o      (done),
    .div_zero_o  (div_zero),
    .quotient_o  (quotient),
    .remainder_o (remainder)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive start for one cycle T; returns in cycle T+1.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s);
    dividend = a;
    divisor  = b;
    sign_op  = s;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Wait (bounded) for done; lat0 is the cycle offset from T we are in now.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic expect_result(input string tag, input int lat0, input int lat_exp,
                               input logic [15:0] q, input logic [15:0] r, input logic dz);
    int lat;
    wait_done(lat0, lat);
    check({tag, "_latency"}, lat, lat_exp);
    check({tag, "_quotient"}, quotient, q);
    check({tag, "_remainder"}, remainder, r);
    check({tag, "_div_zero"}, div_zero, dz);
  endtask

  initial begin
    logic [15:0] pa, pb, na, nb;
    int          lat;
    logic        seen_done;

    rst = 1'b1; start = 1'b0; sign_op = 1'b0; dividend = '0; divisor = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("reset_flags", {ready, busy, done, div_zero}, 4'b1000);
    check("reset_quotient", quotient, 16'd0);
    check("reset_remainder", remainder, 16'd0);

    // Basic 100/7: busy T+1..T+16, done only at T+17
    launch(16'd100, 16'd7, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("basic_busy_T%0d", k), {busy, done, ready}, 3'b100);
      tick();
    end
    check("basic_done_T17", {busy, done, ready}, 3'b011);
    check("basic_quotient", quotient, 16'd14);
    check("basic_remainder", remainder, 16'd2);
    check("basic_div_zero", div_zero, 1'b0);
    tick();
    check("basic_done_pulse", {busy, done, ready}, 3'b001);
    check("basic_hold_quotient", quotient, 16'd14);

    // Zero divisor: done at T+1
    launch(16'd1234, 16'd0, 1'b0);
    expect_result("divzero", 1, 1, 16'hFFFF, 16'd1234, 1'b1);
    tick();
    check("divzero_hold_flag", div_zero, 1'b1);

    // Extreme: 65535/1 clears div_zero
    launch(16'd65535, 16'd1, 1'b0);
    expect_result("max_by_one", 1, 17, 16'd65535, 16'd0, 1'b0);
    tick();

    // Handshake: start while busy ignored, start in DONE accepted
    launch(16'd50000, 16'd300, 1'b0);
    tick(); tick(); tick(); tick();
    dividend = 16'd9; divisor = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_ignored", busy, 1'b1);
    expect_result("hs_first", 6, 17, 16'd166, 16'd200, 1'b0);
    launch(16'd9, 16'd3, 1'b0);
    check("b2b_accept_busy", busy, 1'b1);
    check("b2b_hold_quotient", quotient, 16'd166);
    expect_result("hs_second", 1, 17, 16'd3, 16'd0, 1'b0);
    tick();

    // Reset mid-op at T+8
    launch(16'd1000, 16'd3, 1'b0);
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_flags", {ready, busy, done, div_zero}, 4'b1000);
    check("midrst_quotient", quotient, 16'd0);
    check("midrst_remainder", remainder, 16'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      seen_done |= done;
      tick();
    end
    check("midrst_no_done", seen_done, 1'b0);
    launch(16'd1000, 16'd3, 1'b0);
    expect_result("after_rst", 1, 17, 16'd333, 16'd1, 1'b0);

`ifdef DIVIDER_SIGNED_EN
    launch(16'hFFF9, 16'd2, 1'b1);
    expect_result("s_neg7_by_2", 1, 17, 16'hFFFD, 16'hFFFF, 1'b0);
    launch(16'd7, 16'hFFFE, 1'b1);
    expect_result("s_7_by_neg2", 1, 17, 16'hFFFD, 16'd1, 1'b0);
    launch(16'h8000, 16'hFFFF, 1'b1);
    expect_result("s_overflow", 1, 17, 16'h8000, 16'd0, 1'b0);
    launch(16'hFFF9, 16'd0, 1'b1);
    expect_result("s_divzero", 1, 1, 16'hFFFF, 16'hFFF9, 1'b1);
`else
    // Without signed support sign_op is ignored
    launch(16'hFFF9, 16'd2, 1'b1);
    expect_result("u_sop_neg7_by_2", 1, 17, 16'd32764, 16'd1, 1'b0);
    launch(16'd7, 16'hFFFE, 1'b1);
    expect_result("u_sop_7_by_neg2", 1, 17, 16'd0, 16'd7, 1'b0);
    launch(16'h8000, 16'hFFFF, 1'b1);
    expect_result("u_sop_overflow", 1, 17, 16'd0, 16'h8000, 1'b0);
`endif
    launch(16'hFFF9, 16'd2, 1'b0);
    expect_result("u_65529_by_2", 1, 17, 16'd32764, 16'd1, 1'b0);
    tick();

    // Back-to-back unsigned stream, next op accepted in each DONE cycle
    pa = 16'($urandom_range(0, 65535));
    pb = 16'($urandom_range(1, 65535));
    launch(pa, pb, 1'b0);
    for (int i = 0; i < 200; i++) begin
      wait_done(1, lat);
      check($sformatf("rand%0d_latency", i), lat, 17);
      check($sformatf("rand%0d_%0d_by_%0d", i, pa, pb), {quotient, remainder},
            {pa / pb, pa % pb});
      if (i < 199) begin
        na = 16'($urandom_range(0, 65535));
        nb = (i % 3 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
        launch(na, nb, 1'b0);
        pa = na;
        pb = nb;
      end
    end
    tick();
    check("final_done_pulse", {busy, done, ready}, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
